// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: data width, register index width and
// architecturally fixed register indices.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/rf_read_port.sv
// One combinational register-file read port: index mux, $zero forcing and
// optional same-cycle bypass of the in-flight write.
module rf_read_port
  import mips_pkg::*;
#(
  parameter int unsigned Data_Width = DATA_W,
  parameter int unsigned Addr_Width = REG_AW,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  i_rst_n,
  input  logic [Data_Width-1:0] i_regs [2**Addr_Width],
  input  logic [Addr_Width-1:0] i_addr,
  input  logic                  i_wr_en,
  input  logic [Addr_Width-1:0] i_wr_addr,
  input  logic [Data_Width-1:0] i_wr_data,
  output logic [Data_Width-1:0] o_data
);

  logic w_hit;

  assign w_hit = i_wr_en && (i_wr_addr == i_addr);

  // Zero forcing comes last so it overrides a bypass that targets $zero.
  always_comb begin
    o_data = i_regs[i_addr];
    if (BYPASS && w_hit) begin
      o_data = i_wr_data;
    end
    if (!i_rst_n || (i_addr == Addr_Width'(REG_ZERO))) begin
      o_data = '0;
    end
  end

endmodule : rf_read_port

// File: rtl/register_file.sv
// 32-entry MIPS register file: two combinational read ports with optional
// write bypass, one clocked write port, hardwired $zero and a debug read port.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned Data_Width = DATA_W,
  parameter int unsigned Addr_Width = REG_AW,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Reg_Write,
  input  logic [Addr_Width-1:0] Write_Reg,
  input  logic [Data_Width-1:0] Write_Data,
  input  logic [Addr_Width-1:0] Read_Reg1,
  input  logic [Addr_Width-1:0] Read_Reg2,
  output logic [Data_Width-1:0] Read_Data1,
  output logic [Data_Width-1:0] Read_Data2,
  input  logic [Addr_Width-1:0] Dbg_Addr,
  output logic [Data_Width-1:0] Dbg_Data
);

  localparam int unsigned Depth = 2**Addr_Width;

  logic [Data_Width-1:0] r_regs [1:Depth-1];
  logic [Data_Width-1:0] w_regs [Depth];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 1; i < Depth; i++) begin
        r_regs[i] <= '0;
      end
    end else if (Reg_Write && (Write_Reg != Addr_Width'(REG_ZERO))) begin
      r_regs[Write_Reg] <= Write_Data;
    end
  end

  // Entry 0 is a constant; only entries 1..Depth-1 are flops.
  always_comb begin
    w_regs[0] = '0;
    for (int unsigned i = 1; i < Depth; i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  rf_read_port #(
    .Data_Width(Data_Width),
    .Addr_Width(Addr_Width),
    .BYPASS    (BYPASS)
  ) u_rd1 (
    .i_rst_n  (RST),
    .i_regs   (w_regs),
    .i_addr   (Read_Reg1),
    .i_wr_en  (Reg_Write),
    .i_wr_addr(Write_Reg),
    .i_wr_data(Write_Data),
    .o_data   (Read_Data1)
  );

  rf_read_port #(
    .Data_Width(Data_Width),
    .Addr_Width(Addr_Width),
    .BYPASS    (BYPASS)
  ) u_rd2 (
    .i_rst_n  (RST),
    .i_regs   (w_regs),
    .i_addr   (Read_Reg2),
    .i_wr_en  (Reg_Write),
    .i_wr_addr(Write_Reg),
    .i_wr_data(Write_Data),
    .o_data   (Read_Data2)
  );

  rf_read_port #(
    .Data_Width(Data_Width),
    .Addr_Width(Addr_Width),
    .BYPASS    (1'b0)
  ) u_dbg (
    .i_rst_n  (RST),
    .i_regs   (w_regs),
    .i_addr   (Dbg_Addr),
    .i_wr_en  (1'b0),
    .i_wr_addr(Write_Reg),
    .i_wr_data(Write_Data),
    .o_data   (Dbg_Data)
  );

endmodule : register_file
